// File: rtl/dwt_subband_reorder.sv
// Reorders interleaved L/H DWT coefficient pairs into subband order (all L, then all H) through ping-pong row banks.
// Latency: first coef_o 2 cycles after a row's last pair write; 1 coef/cycle with a 1-cycle bubble between rows.
// Backpressure: coef_o/coef_valid_o held while !coef_ready_i; a row completing with no free bank is dropped (overflow_o). DWT_BAND_TAG_EN adds band/last tags.
module dwt_subband_reorder #(
   parameter int SIZE = 32,
   parameter int DW   = 8,
   parameter int LAT  = 9
) (
   input  logic          sys_clk,
   input  logic          sys_rst,
   input  logic          start_i,
   input  logic [DW-1:0] low_i,
   input  logic [DW-1:0] high_i,
   output logic [DW-1:0] coef_o,
   output logic          coef_valid_o,
   input  logic          coef_ready_i,
   output logic          row_done_o,
   output logic          overflow_o,
   output logic          busy_o
`ifdef DWT_BAND_TAG_EN
   ,
   output logic          coef_band_o,
   output logic          coef_last_o
`endif
);

   localparam int NP = SIZE / 2;
   localparam int IW = $clog2(NP);
   localparam int PW = IW + 1;
   localparam int WW = $clog2(LAT + 1);

   localparam logic [PW-1:0] LAST_PAIR = PW'(NP - 1);
   localparam logic [IW-1:0] LAST_IDX  = IW'(NP - 1);
   localparam logic [IW-1:0] FIRST_IDX = '0;
   localparam logic [WW-1:0] WAIT_END  = WW'(LAT - 1);

   localparam logic [1:0] W_IDLE = 2'd0;
   localparam logic [1:0] W_WAIT = 2'd1;
   localparam logic [1:0] W_CAP  = 2'd2;
   localparam logic [1:0] R_IDLE = 2'd0;
   localparam logic [1:0] R_LOW  = 2'd1;
   localparam logic [1:0] R_HIGH = 2'd2;
   // With LAT==1 the first pair arrives the cycle right after start_i.
   localparam logic [1:0] W_START = (LAT == 1) ? W_CAP : W_WAIT;

   logic [1:0]    w_state, r_state;
   logic [WW-1:0] wait_cnt;
   logic [PW-1:0] pair_cnt;
   logic          phase, row_clean, wb, rb, overflow_q;
   logic [1:0]    full, full_set, full_clr;
   logic [IW-1:0] rd_idx, rd_nxt;
   logic          cap_en, wr_en, cap_last, row_ok, accept, rd_last;

   logic [DW-1:0] mem_l [2][NP];
   logic [DW-1:0] mem_h [2][NP];

   // Writes into a bank still held by the reader are suppressed so its data survives.
   always_comb begin
      cap_en   = (w_state == W_CAP) && !phase && !start_i;
      wr_en    = cap_en && !full[wb];
      cap_last = cap_en && (pair_cnt == LAST_PAIR);
      row_ok   = cap_last && row_clean && !full[wb];
      accept   = coef_valid_o && coef_ready_i;
      rd_last  = accept && (r_state == R_HIGH) && (rd_idx == LAST_IDX);
      rd_nxt   = rd_idx + IW'(1);
      full_set = 2'b00;
      full_clr = 2'b00;
      if (row_ok)  full_set[wb] = 1'b1;
      if (rd_last) full_clr[rb] = 1'b1;
   end

   always_ff @(posedge sys_clk) begin
      if (wr_en) begin
         mem_l[wb][pair_cnt[IW-1:0]] <= low_i;
         mem_h[wb][pair_cnt[IW-1:0]] <= high_i;
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         w_state    <= W_IDLE;
         wait_cnt   <= '0;
         pair_cnt   <= '0;
         phase      <= 1'b0;
         row_clean  <= 1'b0;
         wb         <= 1'b0;
         overflow_q <= 1'b0;
      end else if (start_i) begin
         w_state   <= W_START;
         wait_cnt  <= WW'(1);
         pair_cnt  <= '0;
         phase     <= 1'b0;
         row_clean <= 1'b1;
      end else begin
         case (w_state)
            W_WAIT: begin
               wait_cnt <= wait_cnt + WW'(1);
               if (wait_cnt == WAIT_END) begin
                  w_state <= W_CAP;
                  phase   <= 1'b0;
               end
            end
            W_CAP: begin
               phase <= ~phase;
               if (!phase) begin
                  pair_cnt <= pair_cnt + PW'(1);
                  if (full[wb]) row_clean <= 1'b0;
                  if (cap_last) begin
                     w_state <= W_IDLE;
                     if (row_ok) wb <= ~wb;
                     else        overflow_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) full <= 2'b00;
      else         full <= (full & ~full_clr) | full_set;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         r_state      <= R_IDLE;
         rb           <= 1'b0;
         rd_idx       <= '0;
         coef_o       <= '0;
         coef_valid_o <= 1'b0;
      end else begin
         case (r_state)
            R_IDLE: begin
               if (full[rb]) begin
                  r_state      <= R_LOW;
                  rd_idx       <= FIRST_IDX;
                  coef_o       <= mem_l[rb][FIRST_IDX];
                  coef_valid_o <= 1'b1;
               end
            end
            R_LOW: begin
               if (accept) begin
                  if (rd_idx == LAST_IDX) begin
                     r_state <= R_HIGH;
                     rd_idx  <= FIRST_IDX;
                     coef_o  <= mem_h[rb][FIRST_IDX];
                  end else begin
                     rd_idx <= rd_nxt;
                     coef_o <= mem_l[rb][rd_nxt];
                  end
               end
            end
            R_HIGH: begin
               if (accept) begin
                  if (rd_idx == LAST_IDX) begin
                     r_state      <= R_IDLE;
                     rb           <= ~rb;
                     coef_valid_o <= 1'b0;
                  end else begin
                     rd_idx <= rd_nxt;
                     coef_o <= mem_h[rb][rd_nxt];
                  end
               end
            end
            default: r_state <= R_IDLE;
         endcase
      end
   end

`ifdef DWT_BAND_TAG_EN
   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         coef_band_o <= 1'b0;
         coef_last_o <= 1'b0;
      end else if ((r_state == R_IDLE) && full[rb]) begin
         coef_band_o <= 1'b0;
         coef_last_o <= 1'b0;
      end else if (accept) begin
         if ((r_state == R_LOW) && (rd_idx == LAST_IDX)) begin
            coef_band_o <= 1'b1;
            coef_last_o <= 1'b0;
         end else if (r_state == R_HIGH) begin
            coef_last_o <= !rd_last && (rd_nxt == LAST_IDX);
            if (rd_last) coef_band_o <= 1'b0;
         end
      end
   end
`endif

   assign row_done_o = rd_last;
   assign overflow_o = overflow_q;
   assign busy_o     = (w_state != W_IDLE) || (|full);

endmodule
